// File: rtl/imem_pkg.sv
// Shared constants and PC decode helpers for the synchronous instruction memory.
// The boot image is consumed only in builds with IMEM_BOOT_IMAGE_EN defined.
package imem_pkg;

    localparam logic [0:0] ST_BOOT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    localparam int BOOT_LEN = 7;

    // addi x1,x0,243; addi x2,x0,9; add; and; or; slt; sub
    localparam logic [31:0] BOOT_IMAGE [BOOT_LEN] = '{
        32'h0F30_0093,
        32'h0090_0113,
        32'h0020_8133,
        32'h0020_F1B3,
        32'h0020_E233,
        32'h0041_A333,
        32'h4062_03B3
    };

    function automatic logic pc_misaligned(input logic [63:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

    function automatic logic pc_out_of_range(input logic [63:0] pc, input int unsigned idx_w);
        return (pc >> (idx_w + 2)) != 64'd0;
    endfunction

    function automatic logic pc_fault(input logic [63:0] pc, input int unsigned idx_w);
        return pc_misaligned(pc) || pc_out_of_range(pc, idx_w);
    endfunction

    function automatic logic [63:0] pc_to_index(input logic [63:0] pc);
        return pc >> 2;
    endfunction

    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        w = ZERO_WORD;
        for (int i = 0; i < BOOT_LEN; i++) begin
            if (idx == i) begin
                w = BOOT_IMAGE[i];
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/imem_boot_seq.sv
// Boot sequencer: after reset, writes the boot image into every word, then releases to RUN.
// Instantiated only when IMEM_BOOT_IMAGE_EN is defined.
//
//   state   | meaning
//   ST_BOOT | writing word cnt_q of the image; fetches blocked, loads ignored
//   ST_RUN  | image complete; array under fetch/load control
module imem_boot_seq
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [0:0]        state,
    output logic              boot_we,
    output logic [IDX_W-1:0]  boot_idx,
    output logic [DATA_W-1:0] boot_data
);

    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_BOOT) begin
            if (cnt_q == IDX_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state     = state_q;
    assign boot_we   = (state_q == ST_BOOT);
    assign boot_idx  = cnt_q;
    assign boot_data = DATA_W'(boot_word(32'(cnt_q)));

endmodule

// File: rtl/imem_sync.sv
// Synchronous instruction memory: registered fetch port with fault reporting and a load port.
// Define IMEM_BOOT_IMAGE_EN to fill the array with the boot image after every reset.
module imem_sync
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              fetch_ready,
    input  logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              fault,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_pc,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int IDX_W = $clog2(DEPTH);

    if (((DEPTH & (DEPTH - 1)) != 0) || (DEPTH < 8)) begin : g_bad_depth
        $error("imem_sync: DEPTH must be a power of 2 and at least 8");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              fault_q, fault_d;

    logic [0:0]        state;
    logic              boot_we;
    logic [IDX_W-1:0]  boot_idx;
    logic [DATA_W-1:0] boot_data;

`ifdef IMEM_BOOT_IMAGE_EN
    imem_boot_seq #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_boot_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .boot_we   (boot_we),
        .boot_idx  (boot_idx),
        .boot_data (boot_data)
    );
`else
    assign state     = ST_RUN;
    assign boot_we   = 1'b0;
    assign boot_idx  = '0;
    assign boot_data = '0;
`endif

    logic             fetch_bad, ld_bad, accept;
    logic [IDX_W-1:0] fetch_idx, ld_idx;

    assign fetch_bad   = pc_fault(64'(fetch_pc), IDX_W);
    assign ld_bad      = pc_fault(64'(ld_pc), IDX_W);
    assign fetch_idx   = IDX_W'(pc_to_index(64'(fetch_pc)));
    assign ld_idx      = IDX_W'(pc_to_index(64'(ld_pc)));
    assign fetch_ready = !stall && (state == ST_RUN);
    assign accept      = fetch_req && fetch_ready;

    always_comb begin
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        fault_d       = fault_q;
        if (!stall) begin
            if (accept) begin
                rdata_valid_d = 1'b1;
                fault_d       = fetch_bad;
                if (fetch_bad) begin
                    rdata_d = '0;
                end else begin
                    rdata_d = mem_q[fetch_idx];
                end
            end else begin
                rdata_valid_d = 1'b0;
                fault_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
        end
    end

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = '0;
        mem_wdata = '0;
        if (boot_we) begin
            mem_we    = 1'b1;
            mem_widx  = boot_idx;
            mem_wdata = boot_data;
        end else if ((state == ST_RUN) && ld_we && !ld_bad) begin
            mem_we    = 1'b1;
            mem_widx  = ld_idx;
            mem_wdata = ld_data;
        end
    end

    // Array is never reset; the read above samples the pre-write contents (read-first).
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign fault       = fault_q;

endmodule
